// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state and one-hot result encoding.
package cmp_pkg;

    typedef enum logic {IDLE, SCAN} cmp_state_t;

    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_EQ   = 3'b100,
        RES_LT   = 3'b010,
        RES_GT   = 3'b001
    } cmp_res_t;

endpackage

// File: rtl/digit_cmp.sv
// Combinational DIGIT-bit compare; invert_msb flips both top bits so the digit orders as two's complement.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    input  logic             invert_msb,
    output logic             d_eq,
    output logic             d_gt
);

    logic [DIGIT-1:0] xa;
    logic [DIGIT-1:0] xb;

    always_comb begin
        xa = da;
        xb = db;
        xa[DIGIT-1] = da[DIGIT-1] ^ invert_msb;
        xb[DIGIT-1] = db[DIGIT-1] ^ invert_msb;
        d_eq = (xa == xb);
        d_gt = (xa > xb);
    end

endmodule

// File: rtl/serial_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, early exit on first differing digit.
// Define CMP_SIGNED_EN to add the sgn port and two's-complement compare mode.
module serial_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_param_err
        $error("serial_mag_compare: WIDTH must be a nonzero multiple of DIGIT");
    end

    cmp_state_t       state;
    cmp_res_t         res;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic             invert_msb;
    logic             d_eq;
    logic             d_gt;

`ifdef CMP_SIGNED_EN
    logic sgn_q;
    assign invert_msb = sgn_q && (cnt == CW'(NDIG - 1));
`else
    assign invert_msb = 1'b0;
`endif

    always_comb begin
        da = '0;
        db = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                da = a_q[i*DIGIT +: DIGIT];
                db = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .da         (da),
        .db         (db),
        .invert_msb (invert_msb),
        .d_eq       (d_eq),
        .d_gt       (d_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            res   <= RES_NONE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
`ifdef CMP_SIGNED_EN
            sgn_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
`ifdef CMP_SIGNED_EN
                        sgn_q <= sgn;
`endif
                        cnt   <= CW'(NDIG - 1);
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // The previous result stays visible until this operation decides.
                    if (!d_eq) begin
                        res   <= d_gt ? RES_GT : RES_LT;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        res   <= RES_EQ;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {eq, lt, gt} = res;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Randomised self-checking bench for serial_mag_compare (WIDTH=16, DIGIT=4); honours CMP_SIGNED_EN.
module tb_serial_mag_compare;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy, done, eq, lt, gt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_mag_compare #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef CMP_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .lt    (lt),
        .gt    (gt)
    );

    // Reference: latency is the first MSB-first digit where the prefixes differ; result by plain arithmetic.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                  output int k, output logic [2:0] r);
        k = NDIG;
        for (int d = NDIG; d >= 1; d--)
            if ((ma >> (WIDTH - DIGIT*d)) != (mb >> (WIDTH - DIGIT*d))) k = d;
        if (ma == mb)                                        r = 3'b100;
        else if (ms ? ($signed(ma) < $signed(mb)) : (ma < mb)) r = 3'b010;
        else                                                 r = 3'b001;
    endfunction

    function automatic logic eff_sgn(input logic s);
`ifdef CMP_SIGNED_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    // Launch one compare from the #1-after-edge point and stop on the done cycle (k=-1 on timeout).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          output int k, output logic [2:0] r, output int busy_bad);
        a = ta; b = tb_v; sgn = ts; start = 1'b1;
        k = -1; r = 3'b000; busy_bad = 0;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sgn = ~ts;
        if (!busy) busy_bad++;
        for (int c = 1; c <= NDIG + 2; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (busy) busy_bad++;
                k = c;
                r = {eq, lt, gt};
                break;
            end else if (!busy) begin
                busy_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, eq, lt, gt} !== 5'b0) $display("FAIL reset_asserted got=%b want=00000", {busy, done, eq, lt, gt});
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done, eq, lt, gt} !== 5'b0) $display("FAIL reset_idle cyc=%0d got=%b want=00000", c, {busy, done, eq, lt, gt});
            else passed++;
        end
    endtask

    task automatic test_equal();
        int k, bb; logic [2:0] r;
        run_op(16'h1234, 16'h1234, 1'b0, k, r, bb);
        total++; if (k !== 4) $display("FAIL eq_latency got=%0d want=4", k); else passed++;
        total++; if (r !== 3'b100) $display("FAIL eq_result got=%b want=100", r); else passed++;
        total++; if (bb !== 0) $display("FAIL eq_busy bad_cycles=%0d want=0", bb); else passed++;
        @(posedge clk); #1;
        total++;
        if ({done, eq, lt, gt} !== 4'b0100) $display("FAIL eq_pulse got=%b want=0100", {done, eq, lt, gt});
        else passed++;
    endtask

    task automatic test_early_gt();
        int k, bb, bad; logic [2:0] r;
        run_op(16'h9000, 16'h1000, 1'b0, k, r, bb);
        total++; if (k !== 1) $display("FAIL gt_latency got=%0d want=1", k); else passed++;
        total++; if (r !== 3'b001) $display("FAIL gt_result got=%b want=001", r); else passed++;
        total++; if (bb !== 0) $display("FAIL gt_busy bad_cycles=%0d want=0", bb); else passed++;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if ({busy, done, eq, lt, gt} !== 5'b00001) bad++;
        end
        total++; if (bad !== 0) $display("FAIL gt_hold bad_cycles=%0d want=0", bad); else passed++;
    endtask

    task automatic test_back_to_back();
        int k, bb; logic [2:0] r;
        run_op(16'h12F4, 16'h12F5, 1'b0, k, r, bb);
        total++; if (k !== 4) $display("FAIL b2b_first_latency got=%0d want=4", k); else passed++;
        total++; if (r !== 3'b010) $display("FAIL b2b_first_result got=%b want=010", r); else passed++;
        run_op(16'h0000, 16'h0001, 1'b0, k, r, bb);
        total++; if (k !== 4) $display("FAIL b2b_second_latency got=%0d want=4", k); else passed++;
        total++; if (r !== 3'b010) $display("FAIL b2b_second_result got=%b want=010", r); else passed++;
        total++; if (bb !== 0) $display("FAIL b2b_busy bad_cycles=%0d want=0", bb); else passed++;
    endtask

    task automatic test_signed();
        int k, bb; logic [2:0] r;
`ifdef CMP_SIGNED_EN
        run_op(16'hFFFF, 16'h0001, 1'b1, k, r, bb);
        total++; if (k !== 1) $display("FAIL signed_latency got=%0d want=1", k); else passed++;
        total++; if (r !== 3'b010) $display("FAIL signed_result got=%b want=010", r); else passed++;
        run_op(16'hFFFF, 16'h0001, 1'b0, k, r, bb);
        total++; if (k !== 1) $display("FAIL unsigned_mode_latency got=%0d want=1", k); else passed++;
        total++; if (r !== 3'b001) $display("FAIL unsigned_mode_result got=%b want=001", r); else passed++;
`else
        run_op(16'hFFFF, 16'h0001, 1'b1, k, r, bb);
        total++; if (k !== 1) $display("FAIL nosign_latency got=%0d want=1", k); else passed++;
        total++; if (r !== 3'b001) $display("FAIL nosign_result got=%b want=001", r); else passed++;
`endif
    endtask

    task automatic test_start_ignored();
        int dcount, first;
        a = 16'hAAAA; b = 16'hAAAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0; first = -1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin a = 16'h0000; b = 16'hFFFF; start = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dcount++;
                if (first < 0) first = c;
            end
        end
        total++; if (dcount !== 1) $display("FAIL ignore_done_count got=%0d want=1", dcount); else passed++;
        total++; if (first !== 4) $display("FAIL ignore_done_cycle got=%0d want=4", first); else passed++;
        total++; if ({eq, lt, gt} !== 3'b100) $display("FAIL ignore_result got=%b want=100", {eq, lt, gt}); else passed++;
    endtask

    task automatic test_reset_abort();
        int k, bb, dcount, ek; logic [2:0] r, er;
        a = 16'hAAAA; b = 16'hAAAA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, eq, lt, gt} !== 5'b0) $display("FAIL abort_outputs got=%b want=00000", {busy, done, eq, lt, gt});
        else passed++;
        dcount = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        total++; if (dcount !== 0) $display("FAIL abort_no_done got=%0d want=0", dcount); else passed++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h5A3C, 16'h5A7C, 1'b0, k, r, bb);
        model(16'h5A3C, 16'h5A7C, 1'b0, ek, er);
        total++; if (k !== ek) $display("FAIL after_abort_latency got=%0d want=%0d", k, ek); else passed++;
        total++; if (r !== er) $display("FAIL after_abort_result got=%b want=%b", r, er); else passed++;
    endtask

    task automatic test_random();
        int k, bb, ek; logic [2:0] r, er;
        logic [15:0] ra, rb; logic rs;
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = ra ^ 16'(32'($urandom & 32'hFFFF) >> (DIGIT * $urandom_range(0, NDIG)));
            rs = 1'($urandom);
            model(ra, rb, eff_sgn(rs), ek, er);
            run_op(ra, rb, rs, k, r, bb);
            total++;
            if (k !== ek || r !== er || bb !== 0)
                $display("FAIL random a=%h b=%h s=%b got k=%0d r=%b busy_bad=%0d want k=%0d r=%b",
                         ra, rb, rs, k, r, bb, ek, er);
            else passed++;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early_gt();
        test_back_to_back();
        test_signed();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
